// File: rtl/itch_evt_pkg.sv
// Shared types for the ITCH order-book event path: event opcodes, the replace
// record layout and the replace expander's state encoding.
package itch_evt_pkg;

  typedef enum logic [1:0] {
    EVT_ADD    = 2'd0,
    EVT_CANCEL = 2'd1,
    EVT_DELETE = 2'd2,
    EVT_EXEC   = 2'd3
  } evt_op_t;

  typedef struct packed {
    logic [63:0] old_ref;
    logic [63:0] new_ref;
    logic [31:0] shares;
    logic [31:0] price;
  } replace_rec_t;

  localparam int REPLACE_REC_W = $bits(replace_rec_t);
  localparam int SEQ_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMIT_DEL = 2'd1,
    ST_EMIT_ADD = 2'd2
  } expander_state_t;

endpackage

// File: rtl/itch_sync_fifo.sv
// Single-clock FIFO with registered occupancy. A push while full is accepted
// only when a pop frees a slot in the same cycle; popping an empty FIFO is ignored.
module itch_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/replace_event_expander.sv
// Turns each Replace Order record into a DELETE(old) / ADD(new) beat pair.
// Optional macro REPLACE_EVT_SEQ_EN adds a per-record evt_seq output.
module replace_event_expander
  import itch_evt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        replace_internal_valid,
  input  logic                        replace_packet_invalid,
  input  logic [63:0]                 replace_old_order_ref,
  input  logic [63:0]                 replace_new_order_ref,
  input  logic [31:0]                 replace_shares,
  input  logic [31:0]                 replace_price,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output evt_op_t                     evt_op,
  output logic [63:0]                 evt_order_ref,
  output logic [31:0]                 evt_shares,
  output logic [31:0]                 evt_price,
  output logic                        evt_last,
  output logic                        overflow_pulse,
  output logic [CNT_W-1:0]            drop_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef REPLACE_EVT_SEQ_EN
  ,
  output logic [SEQ_W-1:0]            evt_seq
`endif
);

  // Output stream: a beat transfers on a cycle where evt_valid and evt_ready are
  // both high; while evt_valid is high and evt_ready low every evt_* output holds,
  // and evt_valid only falls after a transfer.

`ifdef REPLACE_EVT_SEQ_EN
  localparam int ENTRY_W = REPLACE_REC_W + SEQ_W;
`else
  localparam int ENTRY_W = REPLACE_REC_W;
`endif

  replace_rec_t    in_rec;
  replace_rec_t    pop_rec;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] pop_data;
  logic            push_req;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            drop;
  logic            load_del;
  logic            load_add;
  logic            go_idle;
  expander_state_t state;
  expander_state_t state_next;
  logic [63:0]     held_new_ref;
  logic [31:0]     held_shares;
  logic [31:0]     held_price;

  assign in_rec   = {replace_old_order_ref, replace_new_order_ref, replace_shares, replace_price};
  assign push_req = replace_internal_valid && !replace_packet_invalid;
  assign drop     = push_req && fifo_full && !pop;

`ifdef REPLACE_EVT_SEQ_EN
  logic [SEQ_W-1:0] seq_ctr;
  logic [SEQ_W-1:0] pop_seq;

  assign push_data = {seq_ctr, in_rec};
  assign pop_seq   = pop_data[ENTRY_W-1 -: SEQ_W];
  assign pop_rec   = pop_data[REPLACE_REC_W-1:0];

  // Numbers are consumed only by records that actually enter the FIFO.
  always_ff @(posedge clk) begin
    if (rst)                               seq_ctr <= '0;
    else if (push_req && (!fifo_full || pop)) seq_ctr <= seq_ctr + SEQ_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)           evt_seq <= '0;
    else if (load_del) evt_seq <= pop_seq;
  end
`else
  assign push_data = in_rec;
  assign pop_rec   = pop_data;
`endif

  itch_sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (push_data),
    .pop   (pop),
    .dout  (pop_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_del   = 1'b0;
    load_add   = 1'b0;
    go_idle    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          load_del   = 1'b1;
          state_next = ST_EMIT_DEL;
        end
      end
      ST_EMIT_DEL: begin
        if (evt_ready) begin
          load_add   = 1'b1;
          state_next = ST_EMIT_ADD;
        end
      end
      ST_EMIT_ADD: begin
        if (evt_ready) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            load_del   = 1'b1;
            state_next = ST_EMIT_DEL;
          end else begin
            go_idle    = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The popped record's ADD half is parked in held_* until the DELETE transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid     <= 1'b0;
      evt_op        <= EVT_ADD;
      evt_order_ref <= '0;
      evt_shares    <= '0;
      evt_price     <= '0;
      evt_last      <= 1'b0;
      held_new_ref  <= '0;
      held_shares   <= '0;
      held_price    <= '0;
    end else if (load_del) begin
      evt_valid     <= 1'b1;
      evt_op        <= EVT_DELETE;
      evt_order_ref <= pop_rec.old_ref;
      evt_shares    <= '0;
      evt_price     <= '0;
      evt_last      <= 1'b0;
      held_new_ref  <= pop_rec.new_ref;
      held_shares   <= pop_rec.shares;
      held_price    <= pop_rec.price;
    end else if (load_add) begin
      evt_op        <= EVT_ADD;
      evt_order_ref <= held_new_ref;
      evt_shares    <= held_shares;
      evt_price     <= held_price;
      evt_last      <= 1'b1;
    end else if (go_idle) begin
      evt_valid     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_pulse <= 1'b0;
      drop_count     <= '0;
    end else begin
      overflow_pulse <= drop;
      if (drop && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_replace_event_expander.sv
// Scoreboard bench for replace_event_expander; honours REPLACE_EVT_SEQ_EN when defined.
module tb_replace_event_expander;
  import itch_evt_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;
  localparam int BW         = 2 + 64 + 32 + 32 + 1 + 16;

  logic        clk;
  logic        rst;
  logic        replace_internal_valid;
  logic        replace_packet_invalid;
  logic [63:0] replace_old_order_ref;
  logic [63:0] replace_new_order_ref;
  logic [31:0] replace_shares;
  logic [31:0] replace_price;
  logic        evt_valid;
  logic        evt_ready;
  evt_op_t     evt_op;
  logic [63:0] evt_order_ref;
  logic [31:0] evt_shares;
  logic [31:0] evt_price;
  logic        evt_last;
  logic        overflow_pulse;
  logic [CNT_W-1:0] drop_count;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [15:0] evt_seq_obs;

`ifdef REPLACE_EVT_SEQ_EN
  logic [15:0] evt_seq;
  assign evt_seq_obs = evt_seq;
`else
  assign evt_seq_obs = '0;
`endif

  replace_event_expander #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .replace_internal_valid (replace_internal_valid),
    .replace_packet_invalid (replace_packet_invalid),
    .replace_old_order_ref  (replace_old_order_ref),
    .replace_new_order_ref  (replace_new_order_ref),
    .replace_shares         (replace_shares),
    .replace_price          (replace_price),
    .evt_valid              (evt_valid),
    .evt_ready              (evt_ready),
    .evt_op                 (evt_op),
    .evt_order_ref          (evt_order_ref),
    .evt_shares             (evt_shares),
    .evt_price              (evt_price),
    .evt_last               (evt_last),
    .overflow_pulse         (overflow_pulse),
    .drop_count             (drop_count),
    .fifo_level             (fifo_level)
`ifdef REPLACE_EVT_SEQ_EN
    ,
    .evt_seq                (evt_seq)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [BW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            beats_acc = 0;
  int            last_acc_cyc = 0;
  int            ovf_seen = 0;
  logic [15:0]   seq_model = '0;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_beat;
  logic [BW-1:0] obs_beat;

  assign obs_beat = {evt_op, evt_order_ref, evt_shares, evt_price, evt_last, evt_seq_obs};

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [BW-1:0] make_beat(input evt_op_t op, input logic [63:0] oref,
                                              input logic [31:0] sh, input logic [31:0] pr,
                                              input logic last, input logic [15:0] seq);
    return {op, oref, sh, pr, last, seq};
  endfunction

  // Monitor: scoreboard pops on transfers; stalled beats must not change.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold", obs_beat, prev_beat);
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) check("spurious_beat", obs_beat, '0);
        else check("beat", obs_beat, exp_q.pop_front());
        beats_acc++;
        last_acc_cyc = cyc;
      end
      if (overflow_pulse) ovf_seen++;
      prev_stall = evt_valid && !evt_ready;
      prev_beat  = obs_beat;
    end
  end

  // Driver tasks
  task automatic send_rec(input logic [63:0] old_ref, input logic [63:0] new_ref,
                          input logic [31:0] sh, input logic [31:0] pr,
                          input logic inv, input logic keep);
    @(posedge clk); #1;
    replace_internal_valid = 1'b1;
    replace_packet_invalid = inv;
    replace_old_order_ref  = old_ref;
    replace_new_order_ref  = new_ref;
    replace_shares         = sh;
    replace_price          = pr;
    if (!inv && keep) begin
      exp_q.push_back(make_beat(EVT_DELETE, old_ref, '0, '0, 1'b0, seq_model));
      exp_q.push_back(make_beat(EVT_ADD, new_ref, sh, pr, 1'b1, seq_model));
`ifdef REPLACE_EVT_SEQ_EN
      seq_model = seq_model + 16'd1;
`endif
    end
    @(posedge clk); #1;
    replace_internal_valid = 1'b0;
    replace_packet_invalid = 1'b0;
    replace_old_order_ref  = '0;
    replace_new_order_ref  = '0;
    replace_shares         = '0;
    replace_price          = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", BW'(n < 300), BW'(1));
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!evt_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", BW'(evt_valid), BW'(1));
  endtask

  initial begin
    int cycles;
    int start_cyc;
    int b0;
    int n;

    rst = 1'b1;
    evt_ready = 1'b0;
    replace_internal_valid = 1'b0;
    replace_packet_invalid = 1'b0;
    replace_old_order_ref  = '0;
    replace_new_order_ref  = '0;
    replace_shares         = '0;
    replace_price          = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_valid", BW'(evt_valid), BW'(0));
    check("rst_level", BW'(fifo_level), BW'(0));
    check("rst_drops", BW'(drop_count), BW'(0));
    check("rst_ovf", BW'(overflow_pulse), BW'(0));
    check("rst_beat", obs_beat, '0);

    // Error-flagged record is ignored and not counted
    send_rec(64'hAA, 64'hBB, 32'd5, 32'd6, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("inv_level", BW'(fifo_level), BW'(0));
    check("inv_drops", BW'(drop_count), BW'(0));
    check("inv_valid", BW'(evt_valid), BW'(0));

    // Single record: DELETE two cycles after the pulse, ADD next, then idle
    evt_ready = 1'b1;
    send_rec(64'h11, 64'h22, 32'd100, 32'h1234, 1'b0, 1'b1);
    cycles = 1;
    @(negedge clk);
    while (!evt_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check("latency", BW'(cycles), BW'(2));
    wait_drain();
    @(negedge clk);
    check("idle_after_pair", BW'(evt_valid), BW'(0));

    // Back-pressure: DELETE stalled 5 cycles, ADD one cycle after ready rises
    @(posedge clk); #1 evt_ready = 1'b0;
    send_rec(64'h33, 64'h44, 32'd7, 32'h99, 1'b0, 1'b1);
    wait_valid();
    repeat (4) @(negedge clk);
    @(posedge clk); #1 evt_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("add_after_ready", BW'({evt_valid, evt_last}), BW'(2'b11));
    wait_drain();

    // Overflow: 6 records with the sink stalled; the sixth is dropped
    @(posedge clk); #1 evt_ready = 1'b0;
    ovf_seen = 0;
    for (int i = 0; i < 6; i++)
      send_rec(64'h100 + 64'(i), 64'h200 + 64'(i), 32'(i + 1), 32'(i * 3), 1'b0, i < 5);
    repeat (2) @(negedge clk);
    check("ovf_pulses", BW'(ovf_seen), BW'(1));
    check("ovf_drops", BW'(drop_count), BW'(1));
    check("ovf_level", BW'(fifo_level), BW'(FIFO_DEPTH));
    @(posedge clk); #1 evt_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check("ovf_level_drained", BW'(fifo_level), BW'(0));

    // Back-to-back: three queued records stream as six consecutive beats
    @(posedge clk); #1 evt_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send_rec(64'h300 + 64'(i), 64'h400 + 64'(i), 32'(50 + i), 32'(70 + i), 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 evt_ready = 1'b1;
    b0 = beats_acc;
    @(posedge clk);
    start_cyc = last_acc_cyc;
    n = 0;
    while (beats_acc < b0 + 6 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("b2b_beats", BW'(beats_acc - b0), BW'(6));
    check("b2b_span", BW'(last_acc_cyc - start_cyc), BW'(5));
    wait_drain();

    // Random records with random sink stalls
    for (int i = 0; i < 12; i++) begin
      send_rec({$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, 1'b0, 1'b1);
      repeat (8) begin
        @(posedge clk); #1 evt_ready = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk); #1 evt_ready = 1'b1;
    wait_drain();

    // Reset while holding the ADD beat discards it
    @(posedge clk); #1 evt_ready = 1'b0;
    send_rec(64'h55, 64'h66, 32'd9, 32'hABC, 1'b0, 1'b1);
    wait_valid();
    @(posedge clk); #1 evt_ready = 1'b1;
    @(posedge clk); #1 evt_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_add", BW'({evt_valid, evt_last}), BW'(2'b11));
    @(posedge clk); #1;
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    seq_model = '0;
    @(negedge clk);
    check("mid_rst_valid", BW'(evt_valid), BW'(0));
    check("mid_rst_level", BW'(fifo_level), BW'(0));
    check("mid_rst_drops", BW'(drop_count), BW'(0));
    evt_ready = 1'b1;
    send_rec(64'h77, 64'h88, 32'd1, 32'd2, 1'b0, 1'b1);
    wait_drain();

    repeat (3) @(posedge clk);
    check("queue_empty", BW'(exp_q.size()), BW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
